param_nr_divider: RTL and testbench

PARAM_NR_DIVIDER -- requirements
Module: param_nr_divider

---
 rtl/param_nr_divider_pkg.sv | 13 +
 rtl/nr_addsub_step.sv | 24 ++
 rtl/param_nr_divider.sv | 149 ++++++++++++++
 tb/tb_param_nr_divider.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/param_nr_divider_pkg.sv
// Shared definitions for the parameterised non-restoring divider.
// Holds the controller state encoding and the default operand width.
package param_nr_divider_pkg;

  localparam int DEFAULT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/nr_addsub_step.sv
// One non-restoring iteration: shift in the next dividend bit, then add or
// subtract the divisor depending on the sign of the incoming partial remainder.
module nr_addsub_step #(
  parameter int W = 32
) (
  input  logic [W+1:0] r,
  input  logic [W-1:0] d,
  input  logic         bit_in,
  output logic [W+1:0] r_next,
  output logic         q_bit,
  output logic         is_add
);

  logic [W+1:0] r_shift;
  logic [W+1:0] d_ext;

  // Two's-complement arithmetic in W+2 bits keeps |R| < 2D without overflow.
  assign r_shift = {r[W:0], bit_in};
  assign d_ext   = {2'b00, d};
  assign is_add  = r[W+1];
  assign r_next  = is_add ? (r_shift + d_ext) : (r_shift - d_ext);
  assign q_bit   = ~r_next[W+1];

endmodule

// File: rtl/param_nr_divider.sv
// Multi-cycle unsigned non-restoring divider with run-time operand lengths,
// divide-by-zero and length-error short paths, and add/subtract counters.
module param_nr_divider
  import param_nr_divider_pkg::*;
#(
  parameter int W  = DEFAULT_W,
  parameter int LW = $clog2(W) + 1,
  parameter int CW = $clog2(W + 2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ready,
  input  logic [W-1:0]  dividend,
  input  logic [W-1:0]  divisor,
  input  logic [LW-1:0] m,
  input  logic [LW-1:0] n,
  output logic          done,
  output logic          out_valid,
  output logic [W-1:0]  q,
  output logic [W-1:0]  rem,
  output logic [CW-1:0] num_add,
  output logic [CW-1:0] num_sub,
  output logic          div_by_zero,
  output logic          len_err
);

  function automatic logic [W-1:0] len_mask(input logic [LW-1:0] len);
    if (len >= LW'(W)) return {W{1'b1}};
    return (W'(1) << len) - W'(1);
  endfunction

  state_t        state_reg;
  logic [W-1:0]  dd_reg;
  logic [W-1:0]  d_reg;
  logic [W+1:0]  r_reg;
  logic [W-1:0]  qacc_reg;
  logic [LW-1:0] cnt_reg;
  logic [CW-1:0] add_cnt_reg;
  logic [CW-1:0] sub_cnt_reg;
  logic          dz_reg;
  logic          le_reg;

  logic          len_bad;
  logic [W-1:0]  dividend_m;
  logic [W-1:0]  divisor_m;
  logic [W+1:0]  r_next;
  logic          q_bit;
  logic          is_add;
  logic          fix_needed;
  logic [W+1:0]  r_final;

  assign len_bad    = (m == '0) || (m > LW'(W)) || (n == '0) || (n > LW'(W));
  assign dividend_m = dividend & len_mask(m);
  assign divisor_m  = divisor & len_mask(n);
  assign fix_needed = r_reg[W+1];
  assign r_final    = fix_needed ? (r_reg + {2'b00, d_reg}) : r_reg;

  nr_addsub_step #(.W(W)) u_step (
    .r      (r_reg),
    .d      (d_reg),
    .bit_in (dd_reg[W-1]),
    .r_next (r_next),
    .q_bit  (q_bit),
    .is_add (is_add)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      dd_reg      <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      qacc_reg    <= '0;
      cnt_reg     <= '0;
      add_cnt_reg <= '0;
      sub_cnt_reg <= '0;
      dz_reg      <= 1'b0;
      le_reg      <= 1'b0;
      done        <= 1'b1;
      out_valid   <= 1'b0;
      q           <= '0;
      rem         <= '0;
      num_add     <= '0;
      num_sub     <= '0;
      div_by_zero <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (ready) begin
            done        <= 1'b0;
            add_cnt_reg <= '0;
            sub_cnt_reg <= '0;
            cnt_reg     <= m;
            // Left-justify so the next bit to consume is always the MSB.
            dd_reg      <= dividend_m << (LW'(W) - m);
            d_reg       <= divisor_m;
            if (len_bad) begin
              le_reg    <= 1'b1;
              dz_reg    <= 1'b0;
              qacc_reg  <= '0;
              r_reg     <= '0;
              state_reg <= FIX;
            end else if (divisor_m == '0) begin
              // Short path: FIX publishes these with no correction since r >= 0.
              le_reg    <= 1'b0;
              dz_reg    <= 1'b1;
              qacc_reg  <= len_mask(m);
              r_reg     <= {2'b00, dividend_m};
              state_reg <= FIX;
            end else begin
              le_reg    <= 1'b0;
              dz_reg    <= 1'b0;
              qacc_reg  <= '0;
              r_reg     <= '0;
              state_reg <= ITER;
            end
          end
        end
        ITER: begin
          r_reg    <= r_next;
          qacc_reg <= {qacc_reg[W-2:0], q_bit};
          dd_reg   <= dd_reg << 1;
          cnt_reg  <= cnt_reg - LW'(1);
          if (is_add) add_cnt_reg <= add_cnt_reg + CW'(1);
          else        sub_cnt_reg <= sub_cnt_reg + CW'(1);
          if (cnt_reg == LW'(1)) state_reg <= FIX;
        end
        FIX: begin
          q           <= qacc_reg;
          rem         <= r_final[W-1:0];
          num_add     <= add_cnt_reg + {{(CW-1){1'b0}}, fix_needed};
          num_sub     <= sub_cnt_reg;
          div_by_zero <= dz_reg;
          len_err     <= le_reg;
          out_valid   <= 1'b1;
          done        <= 1'b1;
          state_reg   <= IDLE;
        end
        default: begin
          done      <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_nr_divider.sv
// Directed self-checking bench for param_nr_divider at W=32 and W=8.
module tb_param_nr_divider;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // W=32 instance
  logic        ready32;
  logic [31:0] a32, b32, q32, rem32;
  logic [5:0]  m32, n32, na32, ns32;
  logic        done32, ov32, dz32, le32;

  // W=8 instance
  logic        ready8;
  logic [7:0]  a8, b8, q8, rem8;
  logic [3:0]  m8, n8, na8, ns8;
  logic        done8, ov8, dz8, le8;

  param_nr_divider #(.W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .ready(ready32), .dividend(a32), .divisor(b32),
    .m(m32), .n(n32), .done(done32), .out_valid(ov32), .q(q32), .rem(rem32),
    .num_add(na32), .num_sub(ns32), .div_by_zero(dz32), .len_err(le32)
  );

  param_nr_divider #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .ready(ready8), .dividend(a8), .divisor(b8),
    .m(m8), .n(n8), .done(done8), .out_valid(ov8), .q(q8), .rem(rem8),
    .num_add(na8), .num_sub(ns8), .div_by_zero(dz8), .len_err(le8)
  );

  logic        cur;
  logic        done_o, ov_o, dz_o, le_o;
  logic [63:0] q_o, rem_o, na_o, ns_o;

  always_comb begin
    if (cur) begin
      done_o = done8; ov_o = ov8; dz_o = dz8; le_o = le8;
      q_o = 64'(q8); rem_o = 64'(rem8); na_o = 64'(na8); ns_o = 64'(ns8);
    end else begin
      done_o = done32; ov_o = ov32; dz_o = dz32; le_o = le32;
      q_o = 64'(q32); rem_o = 64'(rem32); na_o = 64'(na32); ns_o = 64'(ns32);
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one request at a negedge; returns at the negedge after the accept edge.
  task automatic start(input logic sel, input logic [63:0] a, input logic [63:0] b,
                       input int mm, input int nn);
    cur = sel;
    if (!sel) begin
      a32 = a[31:0]; b32 = b[31:0]; m32 = 6'(mm); n32 = 6'(nn); ready32 = 1'b1;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; m8 = 4'(mm); n8 = 4'(nn); ready8 = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    ready32 = 1'b0;
    ready8  = 1'b0;
    $display("start sel=%0d dividend=%0d divisor=%0d m=%0d n=%0d", sel, a, b, mm, nn);
  endtask

  // Counts clock edges after accept until out_valid; optional ready pulse while busy.
  task automatic wait_result(input string tag, input int exp_lat, input logic pulse);
    int lat;
    lat = 0;
    while (!ov_o && lat < 100) begin
      @(negedge clk);
      lat++;
      if (pulse && lat == 1) begin
        if (cur) ready8 = 1'b1; else ready32 = 1'b1;
      end else begin
        ready32 = 1'b0;
        ready8  = 1'b0;
      end
    end
    check({tag, "_valid"}, 64'(ov_o), 64'(1));
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    $display("%s: q=%0d rem=%0d add=%0d sub=%0d dz=%0d le=%0d lat=%0d",
             tag, q_o, rem_o, na_o, ns_o, dz_o, le_o, lat);
  endtask

  task automatic check_result(input string tag, input logic [63:0] eq, input logic [63:0] er,
                              input int ea, input int es, input logic edz, input logic ele);
    check({tag, "_q"}, q_o, eq);
    check({tag, "_rem"}, rem_o, er);
    check({tag, "_add"}, na_o, 64'(ea));
    check({tag, "_sub"}, ns_o, 64'(es));
    check({tag, "_dz"}, 64'(dz_o), 64'(edz));
    check({tag, "_le"}, 64'(le_o), 64'(ele));
  endtask

  initial begin
    cur = 1'b0;
    rst_n = 1'b0;
    ready32 = 1'b0; a32 = '0; b32 = '0; m32 = '0; n32 = '0;
    ready8  = 1'b0; a8  = '0; b8  = '0; m8  = '0; n8  = '0;
    #12;
    check("rst_done", 64'(done_o), 64'(1));
    check("rst_ov", 64'(ov_o), 64'(0));
    check_result("rst", 64'(0), 64'(0), 0, 0, 1'b0, 1'b0);
    check("rst_done8", 64'(done8), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 7/2, m=3, n=2
    start(1'b0, 64'd7, 64'd2, 3, 2);
    check("t1_done_fall", 64'(done_o), 64'(0));
    wait_result("t1", 4, 1'b0);
    check_result("t1", 64'd3, 64'd1, 1, 2, 1'b0, 1'b0);
    @(negedge clk);
    check("t1_pulse_end", 64'(ov_o), 64'(0));
    check("t1_hold_q", q_o, 64'd3);

    // 16/3 with ready pulsed while busy, then back-to-back 53/65
    start(1'b0, 64'd16, 64'd3, 5, 2);
    wait_result("t2", 6, 1'b1);
    check_result("t2", 64'd5, 64'd1, 3, 2, 1'b0, 1'b0);
    check("t2_done", 64'(done_o), 64'(1));
    start(1'b0, 64'd53, 64'd65, 6, 7);
    check("t3_done_fall", 64'(done_o), 64'(0));
    wait_result("t3", 7, 1'b0);
    check_result("t3", 64'd0, 64'd53, 6, 1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_no_extra", 64'(ov_o), 64'(0));
    end

    // Reset in the middle of a long operation
    start(1'b0, 64'hFFFF_FFFF, 64'd3, 32, 2);
    repeat (5) @(negedge clk);
    check("rst_mid_busy", 64'(done_o), 64'(0));
    rst_n = 1'b0;
    #1;
    check("rst_mid_done", 64'(done_o), 64'(1));
    check("rst_mid_rem", rem_o, 64'(0));
    check("rst_mid_add", na_o, 64'(0));
    check("rst_mid_ov", 64'(ov_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_no_stale", 64'(ov_o), 64'(0));
    end
    start(1'b0, 64'd7, 64'd2, 3, 2);
    wait_result("t4", 4, 1'b0);
    check_result("t4", 64'd3, 64'd1, 1, 2, 1'b0, 1'b0);

    // Length errors; divisor 0 with m=0 checks len_err priority
    start(1'b0, 64'd5, 64'd0, 0, 2);
    check("t5_done_fall", 64'(done_o), 64'(0));
    wait_result("t5", 1, 1'b0);
    check_result("t5", 64'd0, 64'd0, 0, 0, 1'b0, 1'b1);
    start(1'b0, 64'd9, 64'd4, 3, 33);
    wait_result("t6", 1, 1'b0);
    check_result("t6", 64'd0, 64'd0, 0, 0, 1'b0, 1'b1);

    // W=8 cases
    start(1'b1, 64'd255, 64'd1, 8, 1);
    wait_result("t7", 9, 1'b0);
    check_result("t7", 64'd255, 64'd0, 0, 8, 1'b0, 1'b0);
    start(1'b1, 64'd5, 64'd0, 3, 2);
    wait_result("t8", 1, 1'b0);
    check_result("t8", 64'd7, 64'd5, 0, 0, 1'b1, 1'b0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
